// File: rtl/opponent_projector.sv
// opponent_projector: projects a world-space target into the forward-view
// window (512..1023 x 512..767). It rotates the target offset into camera
// space using the shared cos/sin ROMs, then runs two divisions on a single
// restoring divider. Latency is fixed at ROM_LATENCY + 51 edges.
module opponent_projector #(
  parameter int ROM_LATENCY = 2,
  parameter int DEPTH_K     = 16384,
  parameter int MIN_DEPTH   = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [8:0]  direction,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [10:0] target_x,
  input  logic [10:0] target_y,
  output logic [8:0]  trig_addr_out,
  input  logic [10:0] cos_in,
  input  logic [10:0] sin_in,
  output logic        busy_out,
  output logic        valid_out,
  output logic        visible_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ROM_WAIT, ST_MULT, ST_ROTATE, ST_DIV_H, ST_DIV_V
  } state_t;

  state_t state_r, state_nxt_s;

  logic [4:0]          cnt_r;
  logic [10:0]         px_r, py_r, tx_r, ty_r;
  logic signed [10:0]  cos_r, sin_r;
  logic signed [22:0]  p_xc_r, p_ys_r, p_xs_r, p_yc_r;
  logic signed [14:0]  cam_x_r, cam_y_r;
  logic [23:0]         rem_r, quo_r, qh_mag_r;

  logic signed [11:0]  dx_s, dy_s;
  logic signed [23:0]  sum_x_s, sum_y_s;
  logic signed [14:0]  cam_x_nxt_s, cam_y_nxt_s;
  logic [14:0]         abs_x_nxt_s;
  logic [23:0]         divisor_s;
  logic [24:0]         trial_s, rem_nxt_s;
  logic                ge_s;
  logic [23:0]         quo_nxt_s;
  logic signed [25:0]  h_s;
  logic                h_in_range_s;
  logic [9:0]          v_s;
  logic                vis_s;

  // Clamp a signed column into the window span.
  function automatic logic [10:0] clamp_h(input logic signed [25:0] h);
    if (h < 26'sd512) begin
      clamp_h = 11'd512;
    end else if (h > 26'sd1023) begin
      clamp_h = 11'd1023;
    end else begin
      clamp_h = h[10:0];
    end
  endfunction

  // Offset, rotation sums and camera coordinates (floor shift by 9 is a slice).
  always_comb begin
    dx_s        = $signed({1'b0, tx_r}) - $signed({1'b0, px_r});
    dy_s        = $signed({1'b0, ty_r}) - $signed({1'b0, py_r});
    sum_x_s     = 24'(p_xc_r) + 24'(p_ys_r);
    sum_y_s     = 24'(p_yc_r) - 24'(p_xs_r);
    cam_x_nxt_s = sum_x_s[23:9];
    cam_y_nxt_s = sum_y_s[23:9];
    if (cam_x_nxt_s[14]) begin
      abs_x_nxt_s = 15'd0 - $unsigned(cam_x_nxt_s);
    end else begin
      abs_x_nxt_s = $unsigned(cam_x_nxt_s);
    end
  end

  // One restoring-divider step; depth below 1 divides by 1.
  always_comb begin
    if (cam_y_r >= 15'sd1) begin
      divisor_s = {9'd0, $unsigned(cam_y_r)};
    end else begin
      divisor_s = 24'd1;
    end
    trial_s = {rem_r, quo_r[23]};
    ge_s    = (trial_s >= {1'b0, divisor_s});
    if (ge_s) begin
      rem_nxt_s = trial_s - {1'b0, divisor_s};
    end else begin
      rem_nxt_s = trial_s;
    end
    quo_nxt_s = {quo_r[22:0], ge_s};
  end

  // Final screen position and visibility from the two quotients.
  always_comb begin
    if (cam_x_r[14]) begin
      h_s = 26'sd767 + $signed({2'b00, qh_mag_r});
    end else begin
      h_s = 26'sd767 - $signed({2'b00, qh_mag_r});
    end
    h_in_range_s = (h_s >= 26'sd512) && (h_s <= 26'sd1023);
    if (quo_nxt_s > 24'd255) begin
      v_s = 10'd767;
    end else begin
      v_s = 10'd512 + {2'b00, quo_nxt_s[7:0]};
    end
    vis_s = (cam_y_r >= $signed(15'(MIN_DEPTH))) && h_in_range_s;
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          state_nxt_s = ST_ROM_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ROM_WAIT: begin
        if (cnt_r == 5'(ROM_LATENCY)) begin
          state_nxt_s = ST_MULT;
        end else begin
          state_nxt_s = ST_ROM_WAIT;
        end
      end
      ST_MULT:   state_nxt_s = ST_ROTATE;
      ST_ROTATE: state_nxt_s = ST_DIV_H;
      ST_DIV_H: begin
        if (cnt_r == 5'd23) begin
          state_nxt_s = ST_DIV_V;
        end else begin
          state_nxt_s = ST_DIV_H;
        end
      end
      ST_DIV_V: begin
        if (cnt_r == 5'd23) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DIV_V;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_r <= 5'd0;
      px_r <= 11'd0; py_r <= 11'd0; tx_r <= 11'd0; ty_r <= 11'd0;
      cos_r <= 11'sd0; sin_r <= 11'sd0;
      p_xc_r <= 23'sd0; p_ys_r <= 23'sd0; p_xs_r <= 23'sd0; p_yc_r <= 23'sd0;
      cam_x_r <= 15'sd0; cam_y_r <= 15'sd0;
      rem_r <= 24'd0; quo_r <= 24'd0; qh_mag_r <= 24'd0;
      trig_addr_out <= 9'd0;
      busy_out      <= 1'b0;
      valid_out     <= 1'b0;
      visible_out   <= 1'b0;
      hcount_out    <= 11'd0;
      vcount_out    <= 10'd0;
    end else begin
      valid_out <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_in) begin
            px_r <= player_x; py_r <= player_y;
            tx_r <= target_x; ty_r <= target_y;
            trig_addr_out <= (direction > 9'd359) ? 9'd0 : direction;
            busy_out <= 1'b1;
            cnt_r    <= 5'd0;
          end else begin
            cnt_r <= 5'd0;
          end
        end
        ST_ROM_WAIT: begin
          if (cnt_r == 5'(ROM_LATENCY)) begin
            cos_r <= $signed(cos_in);
            sin_r <= $signed(sin_in);
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        ST_MULT: begin
          p_xc_r <= 23'(dx_s) * 23'(cos_r);
          p_ys_r <= 23'(dy_s) * 23'(sin_r);
          p_xs_r <= 23'(dx_s) * 23'(sin_r);
          p_yc_r <= 23'(dy_s) * 23'(cos_r);
        end
        ST_ROTATE: begin
          cam_x_r <= cam_x_nxt_s;
          cam_y_r <= cam_y_nxt_s;
          quo_r   <= {1'b0, abs_x_nxt_s, 8'd0};
          rem_r   <= 24'd0;
          cnt_r   <= 5'd0;
        end
        ST_DIV_H: begin
          if (cnt_r == 5'd23) begin
            qh_mag_r <= quo_nxt_s;
            quo_r    <= 24'(DEPTH_K);
            rem_r    <= 24'd0;
            cnt_r    <= 5'd0;
          end else begin
            quo_r <= quo_nxt_s;
            rem_r <= rem_nxt_s[23:0];
            cnt_r <= cnt_r + 5'd1;
          end
        end
        ST_DIV_V: begin
          if (cnt_r == 5'd23) begin
            hcount_out  <= clamp_h(h_s);
            vcount_out  <= v_s;
            visible_out <= vis_s;
            valid_out   <= 1'b1;
            busy_out    <= 1'b0;
            cnt_r       <= 5'd0;
          end else begin
            quo_r <= quo_nxt_s;
            rem_r <= rem_nxt_s[23:0];
            cnt_r <= cnt_r + 5'd1;
          end
        end
        default: begin
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opponent_projector.sv
// Directed, table-driven bench for opponent_projector with a 2-edge trig ROM model.
module tb_opponent_projector;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [8:0]  direction;
  logic [10:0] player_x, player_y, target_x, target_y;
  logic [8:0]  trig_addr_out;
  logic [10:0] cos_in, sin_in;
  logic        busy_out, valid_out, visible_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int dir; int px; int py; int tx; int ty;
    int h; int v; int vis;
  } vec_t;

  vec_t vecs[16];

  always #5 clk_in = ~clk_in;

  opponent_projector dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .direction(direction), .player_x(player_x), .player_y(player_y),
    .target_x(target_x), .target_y(target_y),
    .trig_addr_out(trig_addr_out), .cos_in(cos_in), .sin_in(sin_in),
    .busy_out(busy_out), .valid_out(valid_out), .visible_out(visible_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out)
  );

  // Trig ROM model: two register stages from address to data.
  logic [21:0] rom_d1, rom_d2;
  function automatic logic [21:0] trig_lut(input logic [8:0] a);
    case (a)
      9'd0:    trig_lut = {11'd512, 11'd0};
      9'd30:   trig_lut = {11'd443, 11'd256};
      9'd90:   trig_lut = {11'd0, 11'd512};
      9'd180:  trig_lut = {-11'sd512, 11'd0};
      default: trig_lut = {11'd512, 11'd0};
    endcase
  endfunction
  always @(posedge clk_in) begin
    rom_d1 <= trig_lut(trig_addr_out);
    rom_d2 <= rom_d1;
  end
  assign cos_in = rom_d2[21:11];
  assign sin_in = rom_d2[10:0];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    direction = 9'(v.dir);
    player_x = 11'(v.px); player_y = 11'(v.py);
    target_x = 11'(v.tx); target_y = 11'(v.ty);
  endtask

  // Issue one request, measure latency, compare result.
  task automatic run_one(input vec_t v, input int idx);
    int n;
    int exp_addr;
    n = 0;
    exp_addr = (v.dir > 359) ? 0 : v.dir;
    @(negedge clk_in);
    drive(v);
    start_in = 1'b1;
    @(posedge clk_in); #1;
    check($sformatf("v%0d busy_at_accept", idx), int'(busy_out), 1);
    check($sformatf("v%0d trig_addr", idx), int'(trig_addr_out), exp_addr);
    @(negedge clk_in);
    start_in = 1'b0;
    while (n < 200) begin
      @(posedge clk_in); #1;
      n++;
      if (valid_out) break;
    end
    check($sformatf("v%0d latency", idx), n, 53);
    check($sformatf("v%0d hcount", idx), int'(hcount_out), v.h);
    check($sformatf("v%0d vcount", idx), int'(vcount_out), v.v);
    check($sformatf("v%0d visible", idx), int'(visible_out), v.vis);
    check($sformatf("v%0d busy_at_valid", idx), int'(busy_out), 0);
    @(posedge clk_in); #1;
    check($sformatf("v%0d valid_one_cycle", idx), int'(valid_out), 0);
    check($sformatf("v%0d hcount_hold", idx), int'(hcount_out), v.h);
  endtask

  initial begin
    int valids;
    int first_valid;
    vecs[0]  = '{0,   1000, 1000, 1000, 1200, 767,  593, 1};
    vecs[1]  = '{0,   1000, 1000, 1100, 1200, 639,  593, 1};
    vecs[2]  = '{0,   1000, 1000, 1000, 800,  767,  767, 0};
    vecs[3]  = '{90,  1000, 1000, 800,  1000, 767,  593, 1};
    vecs[4]  = '{90,  1000, 1000, 1200, 1000, 767,  767, 0};
    vecs[5]  = '{0,   1000, 1000, 1300, 1100, 512,  675, 0};
    vecs[6]  = '{0,   1000, 1000, 1000, 1050, 767,  767, 1};
    vecs[7]  = '{0,   1000, 1000, 900,  1200, 895,  593, 1};
    vecs[8]  = '{400, 1000, 1000, 1000, 1200, 767,  593, 1};
    vecs[9]  = '{0,   1000, 1000, 1000, 1032, 767,  767, 1};
    vecs[10] = '{0,   1000, 1000, 1000, 1031, 767,  767, 0};
    vecs[11] = '{30,  1000, 1000, 999,  1000, 1023, 767, 0};
    vecs[12] = '{180, 1000, 1000, 1000, 800,  767,  593, 1};
    vecs[13] = '{0,   1000, 1000, 800,  1200, 1023, 593, 1};
    vecs[14] = '{0,   1000, 1000, 1255, 1256, 512,  576, 1};
    vecs[15] = '{0,   1000, 1000, 1256, 1256, 512,  576, 0};

    rst_in = 1'b0;
    start_in = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk_in);
    #1;
    check("reset busy", int'(busy_out), 0);
    check("reset valid", int'(valid_out), 0);
    check("reset outputs", int'({visible_out, hcount_out, vcount_out, trig_addr_out}), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check("idle busy", int'(busy_out), 0);

    for (int i = 0; i < 16; i++) run_one(vecs[i], i);

    // Start pulses while busy are ignored; exactly one result.
    valids = 0;
    first_valid = 0;
    @(negedge clk_in);
    drive(vecs[1]);
    start_in = 1'b1;
    @(posedge clk_in);
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk_in);
      start_in = (c == 5 || c == 10 || c == 40) ? 1'b1 : 1'b0;
      @(posedge clk_in); #1;
      if (c == 5 || c == 10 || c == 40)
        check($sformatf("hs busy_c%0d", c), int'(busy_out), 1);
      if (valid_out) begin
        valids++;
        if (first_valid == 0) first_valid = c;
      end
    end
    check("hs valid_count", valids, 1);
    check("hs valid_edge", first_valid, 53);
    check("hs hcount", int'(hcount_out), 639);

    // Reset mid-operation.
    @(negedge clk_in);
    drive(vecs[3]);
    start_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (19) @(posedge clk_in);
    #2;
    check("abort busy_before", int'(busy_out), 1);
    rst_in = 1'b0;
    #1;
    check("abort busy", int'(busy_out), 0);
    check("abort trig_addr", int'(trig_addr_out), 0);
    check("abort outputs", int'({valid_out, visible_out, hcount_out, vcount_out}), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    valids = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk_in); #1;
      if (valid_out) valids++;
    end
    check("abort no_valid", valids, 0);

    run_one(vecs[3], 100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/opponent_projector.md
Name: opponent_projector

Overview:
- Inverse of the forward-view pixel-to-world mapping. Takes a world-space target (opponent kart), the player position and the player heading.
- Produces the screen pixel (hcount, vcount) where the target sprite anchors inside the 512..1023 x 512..767 forward-view window, plus a visibility flag.
- Runs once per frame on a start/valid handshake, ahead of the scanline renderer.
- Uses the shared cos/sin ROMs through an address/data port and a single sequential divider.

Parameters:
- ROM_LATENCY, 2, clock edges from trig_addr_out to valid cos_in/sin_in.
- DEPTH_K, 16384, vertical projection constant: v offset = DEPTH_K / cam_y.
- MIN_DEPTH, 32, smallest camera-space depth counted as visible.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- start_in  input  1  request a projection; accepted only in IDLE
- direction  input  9  heading in degrees, 0..359
- player_x  input  11  player world x
- player_y  input  11  player world y
- target_x  input  11  target world x
- target_y  input  11  target world y
- trig_addr_out  output  9  cos/sin ROM address
- cos_in  input  11  signed cos, scaled by 512
- sin_in  input  11  signed sin, scaled by 512
- busy_out  output  1  high from accept until valid_out
- valid_out  output  1  one-cycle result strobe
- visible_out  output  1  target is on screen
- hcount_out  output  11  projected column
- vcount_out  output  10  projected row

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: busy_out, valid_out, visible_out, trig_addr_out, hcount_out, vcount_out.
- IDLE, start_in=1 on an edge:
  - Latch all inputs.
  - trig_addr_out <= direction, or 0 if direction > 359.
  - busy_out <= 1.
  - Go to ROM_WAIT.
- start_in while busy: ignored, no queueing.
- ROM_WAIT: hold for ROM_LATENCY cycles, then capture cos_in/sin_in.
- MULT (1 cycle):
  - dx = target_x - player_x, dy = target_y - player_y, both 12-bit signed.
  - Register the four 23-bit signed products dx*cos, dy*sin, dx*sin, dy*cos.
- ROTATE (1 cycle), 24-bit sums, floor shift, result 15-bit signed:
  - cam_x = (dx*cos + dy*sin) >>> 9
  - cam_y = (dy*cos - dx*sin) >>> 9
- DIV_H (24 cycles): restoring divider, one quotient bit per cycle.
  - Computes q_h = (|cam_x| << 8) / d, with d = cam_y if cam_y >= 1, else d = 1.
  - Truncate toward zero; reapply the sign of cam_x.
- DIV_V (24 cycles): same divider, q_v = DEPTH_K / d.
- DONE (1 cycle):
  - h = 767 - q_h (signed); clamp to [512,1023] for hcount_out.
  - vcount_out = 512 + min(q_v, 255).
  - visible_out = (cam_y >= MIN_DEPTH) && (512 <= unclamped h <= 1023).
  - valid_out = 1 for this cycle, busy_out <= 0, return to IDLE.
- Output hold: hcount/vcount/visible keep their values until the next DONE.
- Fixed latency for every input, including invisible targets: valid_out rises exactly ROM_LATENCY + 51 edges after the accepting edge (53 with the default).
- Next start: may be accepted on the edge after the valid_out cycle.
- Reset mid-operation: abort immediately, clear all outputs; no valid_out for the aborted request.
- Coordinate wrap: player and target are unsigned 0..2047 and dx/dy are full signed differences; there is no toroidal wrap.

Test Plan:
- dir=0 (cos=512, sin=0), player (1000,1000), target (1000,1200) -> cam (0,200); valid at edge 53; h=767, v=593, visible=1.
- dir=0, target (1100,1200) -> cam_x=100, q_h=128; h=639, v=593, visible=1.
- dir=0, target (1000,800) -> cam_y=-200; visible=0, valid still at edge 53.
- dir=90 (cos=0, sin=512), player (1000,1000):
  - target (800,1000) -> cam (0,200); h=767, v=593, visible=1.
  - target (1200,1000) -> visible=0.
- dir=0, target (1300,1100) -> cam (300,100), q_h=768, h=-1; hcount_out=512, visible=0.
- dir=0, target (1000,1050) -> v clamps to 767, visible=1.
- Handshake and reset:
  - start pulses while busy are ignored, busy_out stays 1, exactly one valid_out.
  - rst_in low at cycle 20 of a request: all outputs 0 asynchronously, no valid_out.
  - A new start after reset completes normally.
